// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame generator: pattern modes, 640x480@60
// timing preset and colour packing helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_DATA     = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_BARS     = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;

  // Pack three channels of cb bits (cb <= 8) into {b,g,r}, low 3*cb bits.
  function automatic logic [23:0] pack_bgr(input logic [7:0] b, input logic [7:0] g,
                                           input logic [7:0] r, input int cb);
    logic [7:0] m;
    m = 8'((32'd1 << cb) - 32'd1);
    return (24'(b & m) << (2 * cb)) | (24'(g & m) << cb) | 24'(r & m);
  endfunction

  // cb-bit field of v starting at lsb; bits beyond v's real width read 0.
  function automatic logic [7:0] bit_field(input logic [31:0] v, input int lsb, input int cb);
    logic [31:0] m;
    m = (32'd1 << cb) - 32'd1;
    return 8'((v >> lsb) & m);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counter over active/front/sync/back with region decode.
module vga_axis_counter #(
  parameter int ACTIVE   = 640,
  parameter int FRONT    = 16,
  parameter int SYNC     = 96,
  parameter int BACK     = 48,
  parameter bit SYNC_POL = 1'b0,
  localparam int TOTAL   = ACTIVE + FRONT + SYNC + BACK,
  localparam int CW      = $clog2(TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          sync,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] A_END = CW'(ACTIVE);
  localparam logic [CW-1:0] S_BEG = CW'(ACTIVE + FRONT);
  localparam logic [CW-1:0] S_END = CW'(ACTIVE + FRONT + SYNC);

  assign wrap   = step & (count == LAST);
  assign active = count < A_END;
  assign sync   = (count >= S_BEG && count < S_END) ? SYNC_POL : ~SYNC_POL;

  // advance on step, wrap to 0 after the last back-porch position
  always_ff @(posedge clock) begin
    if (reset)     count <= '0;
    else if (step) count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/vga_frame_generator.sv
// Parametrised VGA timing + pixel generator with pattern modes and a
// LATENCY-deep pipeline so colour lines up with externally fetched data.
module vga_frame_generator import vga_pkg::*; #(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FRONT    = VGA640_H_FRONT,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BACK     = VGA640_H_BACK,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FRONT    = VGA640_V_FRONT,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BACK     = VGA640_V_BACK,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int LATENCY    = 2,
  parameter int H_REPEAT   = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic [3*COLOR_BITS-1:0]       color0,
  input  logic [3*COLOR_BITS-1:0]       color1,
  input  logic                          data,
  output logic                          data_clock_enable,
  output logic [$clog2(H_ACTIVE)-1:0]   x,
  output logic [$clog2(V_ACTIVE)-1:0]   y,
  output logic                          line_start,
  output logic                          frame_start,
  output logic [COLOR_BITS-1:0]         red,
  output logic [COLOR_BITS-1:0]         green,
  output logic [COLOR_BITS-1:0]         blue,
  output logic                          hsync,
  output logic                          vsync
);

  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int HCW     = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam int VCW     = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam int CW3     = 3 * COLOR_BITS;
  localparam int RW      = (H_REPEAT > 1) ? $clog2(H_REPEAT) : 1;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(H_REPEAT - 1);

  // per-pixel context carried down the latency pipeline
  typedef struct packed {
    logic          act;
    logic          hs;
    logic          vs;
    logic          stb;
    logic [1:0]    mode;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  localparam pix_t PIX_IDLE = '{act: 1'b0, hs: ~HSYNC_POL, vs: ~VSYNC_POL, stb: 1'b0,
                                mode: 2'd0, x: '0, y: '0};

  logic [HCW-1:0]       h_cnt;
  logic [VCW-1:0]       v_cnt;
  logic                 h_act, h_sync, h_wrap;
  logic                 v_act, v_sync, v_wrap;
  logic                 act, origin_q;
  logic [RW-1:0]        rep_cnt;
  logic [1:0]           mode_q, mode_eff;
  pix_t                 pix_now, pix_d;
  pix_t [LATENCY:1]     pix_pipe;
  logic                 pix_bit, data_hold;
  logic [2:0]           bar;
  logic [CW3-1:0]       pat;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(HSYNC_POL)
  ) u_h (
    .clock(clock), .reset(reset), .step(1'b1),
    .count(h_cnt), .active(h_act), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(VSYNC_POL)
  ) u_v (
    .clock(clock), .reset(reset), .step(h_wrap),
    .count(v_cnt), .active(v_act), .sync(v_sync), .wrap(v_wrap)
  );

  assign act               = h_act & v_act;
  assign data_clock_enable = act & (rep_cnt == '0) & ~reset;
  assign x                 = (act & ~reset) ? XW'(h_cnt) : '0;
  assign y                 = (act & ~reset) ? YW'(v_cnt) : '0;
  assign line_start        = (h_cnt == '0) & v_act & ~reset;
  assign frame_start       = origin_q & ~reset;

  // origin_q is high exactly while counters sit at (0,0)
  always_ff @(posedge clock) begin
    if (reset) origin_q <= 1'b1;
    else       origin_q <= v_wrap;
  end

  // repeat counter: one fetch per H_REPEAT active cycles, realigned every line
  always_ff @(posedge clock) begin
    if (reset || h_wrap) rep_cnt <= '0;
    else if (act)        rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
  end

  // mode is frame-atomic; the origin pixel already uses the newly latched value
  always_ff @(posedge clock) begin
    if (reset)         mode_q <= MODE_DATA;
    else if (origin_q) mode_q <= mode;
  end

  assign mode_eff = origin_q ? mode : mode_q;
  assign pix_now  = '{act: act, hs: h_sync, vs: v_sync, stb: data_clock_enable,
                      mode: mode_eff, x: x, y: y};

  // delay pixel context by LATENCY so it meets the returning data bit
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 1; k <= LATENCY; k++) pix_pipe[k] <= PIX_IDLE;
    end else begin
      pix_pipe[1] <= pix_now;
      for (int k = 2; k <= LATENCY; k++) pix_pipe[k] <= pix_pipe[k-1];
    end
  end

  assign pix_d   = pix_pipe[LATENCY];
  assign pix_bit = pix_d.stb ? data : data_hold;
  assign bar     = 3'(32'(pix_d.x) / BAR_W);

  // hold the fetched bit across the repeated output cycles
  always_ff @(posedge clock) begin
    if (reset) data_hold <= 1'b0;
    else       data_hold <= pix_bit;
  end

  // pattern select, blanked outside the delayed active window
  always_comb begin
    pat = '0;
    case (pix_d.mode)
      MODE_DATA:     pat = pix_bit ? color1 : color0;
      MODE_GRADIENT: pat = CW3'(pack_bgr(bit_field(32'(pix_d.x), 4, COLOR_BITS),
                                         bit_field(32'(pix_d.y), 1, COLOR_BITS),
                                         bit_field(32'(pix_d.x), 1, COLOR_BITS), COLOR_BITS));
      MODE_BARS:     pat = CW3'(pack_bgr({8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}, COLOR_BITS));
      default:       pat = color1;
    endcase
    if (!pix_d.act) pat = '0;
  end

  // final output register: the last of LATENCY+1 aligned stages
  always_ff @(posedge clock) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
    end else begin
      red   <= pat[COLOR_BITS-1:0];
      green <= pat[2*COLOR_BITS-1:COLOR_BITS];
      blue  <= pat[3*COLOR_BITS-1:2*COLOR_BITS];
      hsync <= pix_d.hs;
      vsync <= pix_d.vs;
    end
  end

endmodule

// File: tb/tb_vga_frame_generator.sv
// Directed bench: small 8x4 raster (14x7 total), LATENCY=2, two instances
// (H_REPEAT=1 and 2) sharing mode/colour inputs.
module tb_vga_frame_generator;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode  = 2'd0;
  logic [11:0] color0 = 12'h000;
  logic [11:0] color1 = 12'hFFF;

  logic       data_a, dce_a, ls_a, fs_a, hs_a, vs_a;
  logic [2:0] x_a;
  logic [1:0] y_a;
  logic [3:0] r_a, g_a, b_a;
  logic       data_b, dce_b, ls_b, fs_b, hs_b, vs_b;
  logic [2:0] x_b;
  logic [1:0] y_b;
  logic [3:0] r_b, g_b, b_b;

  logic da1 = 1'b0, da2 = 1'b0, db1 = 1'b0, db2 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int frame_mode [6];
  int cnt_dce_a = 0, cnt_dce_b = 0, cnt_hs_lo = 0, cnt_vs_lo = 0;

  always #5 clock = ~clock;

  vga_frame_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_BITS(4), .LATENCY(2), .H_REPEAT(1)
  ) dut_a (
    .clock(clock), .reset(reset), .mode(mode), .color0(color0), .color1(color1),
    .data(data_a), .data_clock_enable(dce_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .red(r_a), .green(g_a), .blue(b_a),
    .hsync(hs_a), .vsync(vs_a)
  );

  vga_frame_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_BITS(4), .LATENCY(2), .H_REPEAT(2)
  ) dut_b (
    .clock(clock), .reset(reset), .mode(mode), .color0(color0), .color1(color1),
    .data(data_b), .data_clock_enable(dce_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .red(r_b), .green(g_b), .blue(b_b),
    .hsync(hs_b), .vsync(vs_b)
  );

  // pixel source with 2-cycle latency: alternating bit per fetched pixel
  always @(posedge clock) begin
    da1 <= dce_a & ~x_a[0];
    da2 <= da1;
    db1 <= dce_b & ~x_b[1];
    db2 <= db1;
  end
  assign data_a = da2;
  assign data_b = db2;

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int m, input int h, input int v,
                                          input bit act, input bit rep2);
    bit d;
    if (!act) return 12'h000;
    case (m)
      0: begin
        d = rep2 ? (((h >> 1) % 2) == 0) : ((h % 2) == 0);
        return d ? 12'hFFF : 12'h000;
      end
      1: return {4'h0, 4'(v >> 1), 4'(h >> 1)};
      2: return {((h & 4) != 0) ? 4'hF : 4'h0, ((h & 2) != 0) ? 4'hF : 4'h0,
                 ((h & 1) != 0) ? 4'hF : 4'h0};
      default: return 12'hFFF;
    endcase
  endfunction

  // n = cycles since reset release; outputs lag the counters by 3 cycles
  task automatic check_cycle(input int n);
    int h, v, p, ph, pv, pm;
    bit act, pact;
    h = n % HT; v = (n / HT) % VT;
    act = (h < 8) && (v < 4);
    chk("x_a",   n, 32'(x_a),   act ? 32'(h) : 32'd0);
    chk("y_a",   n, 32'(y_a),   act ? 32'(v) : 32'd0);
    chk("dce_a", n, 32'(dce_a), 32'(act));
    chk("ls_a",  n, 32'(ls_a),  32'((h == 0) && (v < 4)));
    chk("fs_a",  n, 32'(fs_a),  32'((h == 0) && (v == 0)));
    chk("x_b",   n, 32'(x_b),   act ? 32'(h) : 32'd0);
    chk("dce_b", n, 32'(dce_b), 32'(act && (h % 2 == 0)));
    chk("fs_b",  n, 32'(fs_b),  32'((h == 0) && (v == 0)));
    if (n < 3) begin
      chk("rgb_a", n, 32'({b_a, g_a, r_a}), 32'd0);
      chk("hs_a",  n, 32'(hs_a), 32'd1);
      chk("vs_a",  n, 32'(vs_a), 32'd1);
      chk("rgb_b", n, 32'({b_b, g_b, r_b}), 32'd0);
    end else begin
      p = n - 3; ph = p % HT; pv = (p / HT) % VT;
      pact = (ph < 8) && (pv < 4);
      pm = frame_mode[p / FT];
      chk("rgb_a", n, 32'({b_a, g_a, r_a}), 32'(exp_rgb(pm, ph, pv, pact, 1'b0)));
      chk("hs_a",  n, 32'(hs_a), 32'(!(ph == 10 || ph == 11)));
      chk("vs_a",  n, 32'(vs_a), 32'(pv != 5));
      chk("rgb_b", n, 32'({b_b, g_b, r_b}), 32'(exp_rgb(pm, ph, pv, pact, 1'b1)));
      chk("hs_b",  n, 32'(hs_b), 32'(!(ph == 10 || ph == 11)));
    end
  endtask

  task automatic check_reset_state(input int n);
    chk("rst_rgb_a", n, 32'({b_a, g_a, r_a}), 32'd0);
    chk("rst_hs_a",  n, 32'(hs_a),  32'd1);
    chk("rst_vs_a",  n, 32'(vs_a),  32'd1);
    chk("rst_dce_a", n, 32'(dce_a), 32'd0);
    chk("rst_ls_a",  n, 32'(ls_a),  32'd0);
    chk("rst_fs_a",  n, 32'(fs_a),  32'd0);
    chk("rst_x_a",   n, 32'(x_a),   32'd0);
    chk("rst_y_a",   n, 32'(y_a),   32'd0);
    chk("rst_rgb_b", n, 32'({b_b, g_b, r_b}), 32'd0);
    chk("rst_hs_b",  n, 32'(hs_b),  32'd1);
  endtask

  initial begin
    // modes by frame: data, data, solid (set at v=2 of f1), bars, gradient
    frame_mode = '{0, 0, 3, 2, 1, 1};

    repeat (3) @(posedge clock);
    #2 check_reset_state(-1);

    @(posedge clock);
    #1 reset = 1'b0;
    #1 check_cycle(0);
    if (dce_a) cnt_dce_a++;
    if (dce_b) cnt_dce_b++;

    for (int n = 1; n <= 5 * FT + HT + 13; n++) begin
      @(posedge clock);
      #1;
      if (n == FT + 28)     mode = 2'd3;
      if (n == 2 * FT + 28) mode = 2'd2;
      if (n == 3 * FT + 28) mode = 2'd1;
      #1 check_cycle(n);
      if (n < FT) begin
        if (dce_a) cnt_dce_a++;
        if (dce_b) cnt_dce_b++;
      end
      if (n >= 3 && n < FT + 3) begin
        if (!hs_a) cnt_hs_lo++;
        if (!vs_a) cnt_vs_lo++;
      end
    end

    chk("dce_a_per_frame", 0, 32'(cnt_dce_a), 32'd32);
    chk("dce_b_per_frame", 0, 32'(cnt_dce_b), 32'd16);
    chk("hs_low_per_frame", 0, 32'(cnt_hs_lo), 32'd14);
    chk("vs_low_per_frame", 0, 32'(cnt_vs_lo), 32'd14);

    // reset for 3 cycles while hsync is low (output pixel h=10, line 1)
    chk("hs_low_before_reset", 0, 32'(hs_a), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #2 check_reset_state(k);
    end

    // restart: gradient mode is live at the new frame origin
    frame_mode = '{1, 1, 1, 1, 1, 1};
    reset = 1'b0;
    #1 check_cycle(0);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #2 check_cycle(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_generator.md
# vga_frame_generator

Parametrised VGA timing and pixel generator. It replaces the fixed 640x480 frame controller in the display path. Timing, sync polarity, colour depth, pixel-data latency and horizontal pixel repeat are all set by parameters. It drives the monitor pins directly, issues per-pixel data requests to the capture/VRAM side, and inserts built-in test patterns on demand.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, cycles
- H_SYNC, 96: horizontal sync width, cycles
- H_BACK, 48: horizontal back porch, cycles
- V_ACTIVE, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BACK, 33: vertical back porch, lines
- HSYNC_POL, 0: active level of hsync
- VSYNC_POL, 0: active level of vsync
- COLOR_BITS, 4: bits per colour channel
- LATENCY, 2: cycles from data_clock_enable to a valid `data` input (1..8)
- H_REPEAT, 1: output cycles per fetched pixel (1..4); H_ACTIVE must be a multiple of it

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- mode  in  2  0 = data, 1 = gradient, 2 = colour bars, 3 = solid color1
- color0  in  3*COLOR_BITS  background colour {b,g,r}, used when data=0
- color1  in  3*COLOR_BITS  foreground colour {b,g,r}
- data  in  1  pixel bit, valid LATENCY cycles after its request
- data_clock_enable  out  1  pixel request strobe
- x  out  $clog2(H_ACTIVE)  current pixel column (undelayed)
- y  out  $clog2(V_ACTIVE)  current line (undelayed)
- line_start  out  1  1-cycle pulse at h=0 of every active line
- frame_start  out  1  1-cycle pulse at h=0, v=0
- red, green, blue  out  COLOR_BITS each  pixel colour, registered
- hsync, vsync  out  1 each  sync outputs, registered

## Operation
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL is the sum of the four H parameters. It wraps to 0.
- v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1.
- Region order on both axes: active (starting at 0), front, sync, back.
- h_active = h_cnt < H_ACTIVE. v_active = v_cnt < V_ACTIVE.
- hsync is asserted while H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC. vsync follows the same rule on v_cnt.
- x = h_cnt and y = v_cnt while active; both read 0 outside the active region.
- rep_cnt (0..H_REPEAT-1) counts only in active cycles and clears at h_cnt=0.
- data_clock_enable = h_active & v_active & (rep_cnt==0) & ~reset.
- The sampled `data` bit is held for the H_REPEAT output cycles of that pixel.
- Mode is latched into mode_q only when h_cnt=0 and v_cnt=0. A mid-frame change takes effect at the next frame.
- Colour per mode:
  - mode 0: data ? color1 : color0.
  - mode 1: red = x[COLOR_BITS:1]; green = y[COLOR_BITS:1]; blue = x[COLOR_BITS+3:4]. Bits above the counter width read 0.
  - mode 2: 8 vertical bars, each H_ACTIVE/8 wide, with bar index b = 0..7. A channel is all-ones when its bit of b is set (red = b[0], green = b[1], blue = b[2]), otherwise 0.
  - mode 3: color1.
- Colour is forced to 0 outside the delayed active region.
- Reset puts h_cnt, v_cnt, rep_cnt and mode_q at 0 and clears the delay pipeline.

## Timing
- Let t be the cycle in which counters read (h,v). Then:
  - `data` for that pixel is sampled at t+LATENCY.
  - red/green/blue, hsync and vsync for that pixel appear at t+LATENCY+1.
- Sync and blank pass through a shift register of LATENCY+1 stages, so colour and sync stay aligned.
- x, y, line_start, frame_start and data_clock_enable are undelayed (cycle t).
- Reset values:
  - red/green/blue = 0; hsync = ~HSYNC_POL; vsync = ~VSYNC_POL.
  - data_clock_enable, line_start, frame_start = 0; x = y = 0.
- First cycle after reset deasserts: counters read (0,0) and frame_start=1.
- For the first LATENCY+1 cycles after reset the outputs keep their reset values, because the pipeline is cleared.
- Reset mid-frame aborts the frame with no partial sync pulse: the delayed sync bits are cleared.
- Wrap-around: at h=H_TOTAL-1, v=V_TOTAL-1 the next cycle is (0,0) with frame_start=1.
- Periods: hsync repeats every H_TOTAL cycles; vsync every H_TOTAL*V_TOTAL cycles.

## Structure
- Package vga_pkg holds:
  - mode encodings (MODE_DATA, MODE_GRADIENT, MODE_BARS, MODE_SOLID);
  - the 640x480@60 timing preset constants;
  - the colour-packing helper for {b,g,r}.
- Sub-module vga_axis_counter (params ACTIVE, FRONT, SYNC, BACK, SYNC_POL; inputs clock, reset, step) outputs count, active, sync and wrap. It is instantiated twice:
  - horizontal, with step = 1;
  - vertical, with step = the horizontal wrap.

## Test plan
- Defaults, run 2 frames → hsync low for exactly 96 cycles every 800; vsync low for exactly 1600 cycles every 420000; 640*480 data_clock_enable pulses per frame.
- H_ACTIVE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_ACTIVE=4, V_FRONT=V_SYNC=V_BACK=1, LATENCY=2, mode 0; drive data = alternating 1/0 delayed 2 cycles, color1=12'hFFF, color0=12'h000 → rgb toggles FFF/000 starting 3 cycles after the first strobe; hsync rises and falls at the delayed boundary, aligned with the blank.
- Same configuration with H_REPEAT=2 → 4 strobes per line on cycles h=0,2,4,6; each colour held 2 cycles.
- Mode changed 0→3 at v=2 → colour stays data-driven until the next frame_start, then is solid color1.
- Mode 2 with default timing → red toggles every 80 pixels; blue=4'hF for x=320..639 and 0 below.
- Reset asserted for 3 cycles mid-line → outputs take their reset values the cycle after reset is sampled; after release frame_start=1, rgb=0 for 3 cycles, then valid data.
